// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO stream reader slice.
// Buffer state encoding doubles as the occupancy count.
package fifo_stream_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } buf_state_t;

   localparam int unsigned BUF_DEPTH = 2;
   localparam int unsigned OCC_WIDTH = 2;

   function automatic logic [OCC_WIDTH-1:0] occ_of(input buf_state_t s);
      logic [OCC_WIDTH-1:0] occ;
      case (s)
         ONE:     occ = 2'd1;
         TWO:     occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order buffer; head is a register and is always the oldest word.
// Push writes din at the end of the cycle; pop retires the head.
module stream_skid_buf
   import fifo_stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [OCC_WIDTH-1:0]  occ,
   output logic [DATA_WIDTH-1:0] head
);

   buf_state_t            state, state_nxt;
   logic [DATA_WIDTH-1:0] head_q, tail_q, head_nxt, tail_nxt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= EMPTY;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         state  <= state_nxt;
         head_q <= head_nxt;
         tail_q <= tail_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      head_nxt  = head_q;
      tail_nxt  = tail_q;
      case (state)
         EMPTY: begin
            if (push) begin
               state_nxt = ONE;
               head_nxt  = din;
            end
         end
         ONE: begin
            case ({push, pop})
               2'b10: begin
                  state_nxt = TWO;
                  tail_nxt  = din;
               end
               2'b01: state_nxt = EMPTY;
               2'b11: head_nxt = din;
               default: ;
            endcase
         end
         TWO: begin
            // push without pop is excluded upstream; push with pop rotates the entries
            if (pop) begin
               head_nxt = tail_q;
               if (push) tail_nxt = din;
               else      state_nxt = ONE;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   assign occ  = occ_of(state);
   assign head = head_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency FIFO into a valid/ready stream without dropping words.
// Reads are issued only when the 2-entry buffer can absorb the returning data.
module fifo_stream_reader
   import fifo_stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  fifo_empty,
   output logic                  fifo_rd,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0]  word_count,
   output logic                  busy
);

   logic                 inflight;
   logic                 pop;
   logic                 room;
   logic [OCC_WIDTH-1:0] occ;

   assign pop  = out_valid & out_ready;
   // words already held plus the one returning must leave a free slot
   assign room = ({1'b0, occ} + {2'b00, inflight}) < 3'(BUF_DEPTH);
   assign fifo_rd = reset & en & ~fifo_empty & (room | pop);

   always_ff @(posedge clk) begin
      if (!reset) begin
         inflight   <= 1'b0;
         word_count <= '0;
      end else begin
         inflight <= fifo_rd;
         if (pop) word_count <= word_count + CNT_WIDTH'(1);
      end
   end

   stream_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk   (clk),
      .reset (reset),
      .push  (inflight),
      .pop   (pop),
      .din   (fifo_rdata),
      .occ   (occ),
      .head  (out_data)
   );

   assign out_valid = (occ != '0);
   assign busy      = out_valid | inflight;

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side client of the team's FIFO controller plus synchronous RAM.
- Drains words from the FIFO, which has one cycle of read latency, and presents them on a valid/ready stream.
- Issues reads only when it can absorb the returning data, so no word is ever dropped when the downstream consumer stalls.
- Keeps a running count of delivered words for status and debug.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and stream data.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset; asserted when 0.
- en  in  1  read enable; when 0, no new FIFO reads are issued.
- fifo_empty  in  1  empty flag from the FIFO controller.
- fifo_rd  out  1  read strobe to the FIFO controller.
- fifo_rdata  in  DATA_WIDTH  RAM read data; valid in the cycle after fifo_rd.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream accepts when high together with out_valid.
- out_data  out  DATA_WIDTH  stream data; registered.
- word_count  out  CNT_WIDTH  number of completed stream handshakes, modulo 2^CNT_WIDTH.
- busy  out  1  high while the buffer is non-empty or a read is in flight.

Behaviour:
- Reset is synchronous and active-low: one cycle with reset==0 clears all state at the next edge.
  - While reset==0, fifo_rd is forced to 0.
  - After reset: out_valid=0, out_data=0, word_count=0, busy=0, buffer state EMPTY, inflight=0.
- Internal 2-entry output buffer with states EMPTY, ONE, TWO (occ = 0/1/2). inflight is a flop set in the cycle after fifo_rd=1.
- Definitions: pop = out_valid & out_ready; push = inflight (fifo_rdata is written into the buffer at the end of that cycle).
- fifo_rd = reset & en & ~fifo_empty & ((occ + inflight < 2) | pop). This is combinational.
- fifo_rd is never asserted while fifo_empty=1, regardless of pop.
- State transitions:
  - EMPTY: on push, go to ONE.
  - ONE: push&~pop goes to TWO; pop&~push goes to EMPTY; push&pop stays in ONE.
  - TWO: on pop, go to ONE. push&~pop in TWO cannot occur; the read-issue rule prevents it, and the bench asserts this.
- Buffer ordering is FIFO: out_data is always the oldest entry.
- On push&pop in ONE, the new word becomes the head in the next cycle.
- out_valid = (occ != 0). out_data holds steady while out_valid=1 and out_ready=0.
- Latency:
  - fifo_rd in cycle t; data sampled at the end of t+1; out_valid first high in t+2 when the buffer was empty.
  - Throughput is 1 word/cycle with out_ready held high.
- word_count increments by 1 on each pop and wraps from 2^CNT_WIDTH-1 to 0.
- busy = (occ != 0) | inflight.
- en falling mid-stream: a read already in flight still lands in the buffer, and buffered words still drain; no new reads are issued.
- out_ready low for any length of time: at most 2 words are held; further reads are suppressed until a pop.
- Reset asserted mid-operation: buffered and in-flight words are discarded and the counter is cleared.
  - The FIFO side is reset by the same reset, so no stale in-flight data is captured.

Decomposition:
- Package fifo_stream_pkg holds:
  - typedef enum buf_state_t {EMPTY, ONE, TWO};
  - localparam BUF_DEPTH = 2.
- One sub-module: stream_skid_buf, a 2-entry buffer with push/pop and occ/head outputs, parameterised on DATA_WIDTH.
- The top level holds the read-issue logic, the inflight flop and word_count.

Test Plan:
- Reset: hold reset=0 for 2 cycles with fifo_empty=0, en=1 -> fifo_rd=0 throughout; after release, out_valid=0, word_count=0, busy=0.
- Streaming: FIFO preloaded with 0x11..0x18, out_ready=1, en=1 -> first fifo_rd at cycle 0, out_valid at cycle 2, then 0x11..0x18 on consecutive cycles; word_count=8; busy=0 after the FIFO empties.
- Backpressure: 6 words queued, out_ready=0 for 10 cycles -> exactly 2 fifo_rd pulses, state TWO, out_data=first word held stable; release out_ready -> all 6 delivered in order, no loss or duplication.
- Empty boundary: FIFO holds 1 word, out_ready=1 -> one fifo_rd only; fifo_rd stays 0 while fifo_empty=1; out_valid high for exactly 1 cycle.
- Enable drop: streaming, then en=0 in the same cycle as a read -> the in-flight word is still delivered; no further fifo_rd; en=1 resumes in order.
- Counter wrap and mid-reset: CNT_WIDTH=4, 17 words delivered -> word_count=1; then reset=0 while occ=2 -> out_valid=0, word_count=0 next cycle.
